// File: rtl/mdu_iter_if.sv
// Start/busy/done handshake and operand/result bus between the core FSM and
// the iterative multiply/divide unit.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply (UMULL/SMULL) and restoring divide (UDIV/SDIV).
// Signed ops run on magnitudes; sign fix-up is applied on the edge into DONE.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               is_div_r;
  logic               neg_res_r;
  logic               neg_rem_r;
  logic [WIDTH:0]     hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic [WIDTH-1:0]   opnd_r;
  logic               busy_r;
  logic               done_r;
  logic               dbz_r;
  logic [WIDTH-1:0]   res_lo_r;
  logic [WIDTH-1:0]   res_hi_r;

  logic               sign_a_s;
  logic               sign_b_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic               div_zero_s;
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH:0]     mac_s;
  logic [WIDTH:0]     step_hi_s;
  logic [WIDTH-1:0]   step_lo_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;
  logic [WIDTH-1:0]   fin_lo_s;
  logic [WIDTH-1:0]   fin_hi_s;

  // Operand decode at request time: signs, magnitudes, divide-by-zero bypass.
  always_comb begin
    sign_a_s   = bus.op[0] & bus.a[WIDTH-1];
    sign_b_s   = bus.op[0] & bus.b[WIDTH-1];
    mag_a_s    = sign_a_s ? ({WIDTH{1'b0}} - bus.a) : bus.a;
    mag_b_s    = sign_b_s ? ({WIDTH{1'b0}} - bus.b) : bus.b;
    div_zero_s = bus.op[1] & (bus.b == {WIDTH{1'b0}});
  end

  // One iteration of the shared datapath plus the sign-corrected final result.
  always_comb begin
    rem_sh_s = {hi_r[WIDTH-1:0], lo_r[WIDTH-1]};
    diff_s   = rem_sh_s - {1'b0, opnd_r};
    if (lo_r[0]) begin
      mac_s = hi_r + {1'b0, opnd_r};
    end else begin
      mac_s = hi_r;
    end
    if (is_div_r) begin
      if (rem_sh_s >= {1'b0, opnd_r}) begin
        step_hi_s = diff_s;
        step_lo_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        step_hi_s = rem_sh_s;
        step_lo_s = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Shift-add: the carry out of the add lands back in the top bit.
      step_hi_s = {1'b0, mac_s[WIDTH:1]};
      step_lo_s = {mac_s[0], lo_r[WIDTH-1:1]};
    end

    prod_s     = {step_hi_s[WIDTH-1:0], step_lo_s};
    prod_fix_s = neg_res_r ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;
    quo_fix_s  = neg_res_r ? ({WIDTH{1'b0}} - step_lo_s) : step_lo_s;
    rem_fix_s  = neg_rem_r ? ({WIDTH{1'b0}} - step_hi_s[WIDTH-1:0]) : step_hi_s[WIDTH-1:0];
    if (is_div_r) begin
      fin_lo_s = quo_fix_s;
      fin_hi_s = rem_fix_s;
    end else begin
      fin_lo_s = prod_fix_s[WIDTH-1:0];
      fin_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM, iteration registers and registered handshake/result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      hi_r      <= {(WIDTH+1){1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      opnd_r    <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dbz_r     <= 1'b0;
      res_lo_r  <= {WIDTH{1'b0}};
      res_hi_r  <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          if (bus.start) begin
            if (div_zero_s) begin
              state_r  <= DONE;
              done_r   <= 1'b1;
              res_lo_r <= {WIDTH{1'b0}};
              res_hi_r <= bus.a;
              dbz_r    <= 1'b1;
            end else begin
              state_r   <= BUSY;
              busy_r    <= 1'b1;
              cnt_r     <= {CNT_W{1'b0}};
              is_div_r  <= bus.op[1];
              neg_res_r <= sign_a_s ^ sign_b_s;
              neg_rem_r <= sign_a_s;
              hi_r      <= {(WIDTH+1){1'b0}};
              // Divide shifts the dividend out of lo; multiply shifts the multiplier.
              lo_r      <= bus.op[1] ? mag_a_s : mag_b_s;
              opnd_r    <= bus.op[1] ? mag_b_s : mag_a_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          hi_r <= step_hi_s;
          lo_r <= step_lo_s;
          if (cnt_r == CNT_W'(WIDTH-1)) begin
            state_r  <= DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            res_lo_r <= fin_lo_s;
            res_hi_r <= fin_hi_s;
            dbz_r    <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.result_lo   = res_lo_r;
  assign bus.result_hi   = res_hi_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (WIDTH=32): directed vector table, multi-cycle
// corner sequences and randomized ops against a 64-bit arithmetic reference.
module tb_mdu_iter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if #(.WIDTH(32)) bus ();
  mdu_iter #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          lat;
  int          bcnt;
  logic [31:0] got_lo;
  logic [31:0] got_hi;
  logic        got_dbz;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi, output logic dbz);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    lo  = 32'h0;
    hi  = 32'h0;
    case (op)
      2'b00: begin
        p  = {32'h0, a} * {32'h0, b};
        lo = p[31:0];
        hi = p[63:32];
      end
      2'b01: begin
        p  = sa * sb;
        lo = p[31:0];
        hi = p[63:32];
      end
      default: begin
        if (b == 32'h0) begin
          lo  = 32'h0;
          hi  = a;
          dbz = 1'b1;
        end else if (op == 2'b10) begin
          lo = a / b;
          hi = a % b;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          lo = q[31:0];
          hi = r[31:0];
        end
      end
    endcase
  endfunction

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
  endtask

  // Observes cycles 1.. after the start edge; with noise, pokes start/op/a/b while busy.
  task automatic wait_done(input bit noise);
    bit got;
    got  = 1'b0;
    lat  = 0;
    bcnt = 0;
    for (int k = 1; k <= 100 && !got; k++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (bus.done) begin
        got     = 1'b1;
        lat     = k;
        got_lo  = bus.result_lo;
        got_hi  = bus.result_hi;
        got_dbz = bus.div_by_zero;
        bus.start = 1'b0;
      end else if (noise) begin
        bus.start = 1'($urandom_range(1));
        bus.op    = 2'($urandom_range(3));
        bus.a     = $urandom;
        bus.b     = $urandom_range(1) ? 32'h0 : $urandom;
      end else begin
        bus.start = 1'b0;
      end
    end
    if (!got) begin
      total_cnt++;
      $display("FAIL done_timeout: got no done within 100 cycles, required done");
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] lo, input logic [31:0] hi,
                              input logic dbz);
    chk({tag, "_lo"}, 64'(got_lo), 64'(lo));
    chk({tag, "_hi"}, 64'(got_hi), 64'(hi));
    chk({tag, "_dbz"}, 64'(got_dbz), 64'(dbz));
    chk({tag, "_latency"}, 64'(lat), dbz ? 64'd1 : 64'd33);
    chk({tag, "_busy_cycles"}, 64'(bcnt), dbz ? 64'd0 : 64'd32);
  endtask

  initial begin
    logic [31:0] e_lo;
    logic [31:0] e_hi;
    logic        e_dbz;
    int          done_seen;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{2'b10, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
    vecs[3]  = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
    vecs[5]  = '{2'b10, 32'd5,        32'd0,        32'd0,        32'd5,        1'b1};
    vecs[6]  = '{2'b00, 32'd2,        32'd3,        32'd6,        32'd0,        1'b0};
    vecs[7]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
    vecs[8]  = '{2'b11, 32'hFFFFFFF7, 32'd0,        32'd0,        32'hFFFFFFF7, 1'b1};
    vecs[9]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0};
    vecs[10] = '{2'b10, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
    vecs[11] = '{2'b10, 32'd3,        32'd10,       32'd0,        32'd3,        1'b0};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_lo", 64'(bus.result_lo), 64'd0);
    chk("reset_hi", 64'(bus.result_hi), 64'd0);
    chk("reset_dbz", 64'(bus.div_by_zero), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(1'b0);
      check_result($sformatf("vec%0d", i), vecs[i].lo, vecs[i].hi, vecs[i].dbz);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), 64'(bus.done), 64'd0);
      chk($sformatf("vec%0d_hold_lo", i), 64'(bus.result_lo), 64'(vecs[i].lo));
    end

    // Back-to-back: second SMULL is started in the done cycle of the first.
    @(negedge clk);
    launch(2'b01, 32'hFFFFFFFD, 32'd7);
    wait_done(1'b0);
    check_result("b2b_first", 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0);
    launch(2'b01, 32'h80000000, 32'h80000000);
    wait_done(1'b0);
    check_result("b2b_second", 32'h0, 32'h40000000, 1'b0);

    // Back-to-back divide-by-zero gives done on two consecutive cycles.
    @(negedge clk);
    launch(2'b10, 32'd11, 32'd0);
    wait_done(1'b0);
    check_result("b2b_dbz_first", 32'd0, 32'd11, 1'b1);
    launch(2'b11, 32'd12, 32'd0);
    wait_done(1'b0);
    check_result("b2b_dbz_second", 32'd0, 32'd12, 1'b1);

    // start and operand changes while busy must not disturb the running op.
    @(negedge clk);
    launch(2'b00, 32'd12345, 32'd678);
    wait_done(1'b1);
    check_result("ignore_start", 32'd8369910, 32'd0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;

    // Reset mid-operation: immediate clear and no done afterwards.
    @(negedge clk);
    launch(2'b10, 32'd9, 32'd0);
    wait_done(1'b0);
    check_result("pre_reset_dbz", 32'd0, 32'd9, 1'b1);
    @(negedge clk);
    launch(2'b00, 32'h0000FFFF, 32'h0000FFFF);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midop_busy_before_reset", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("midop_reset_busy", 64'(bus.busy), 64'd0);
    chk("midop_reset_done", 64'(bus.done), 64'd0);
    chk("midop_reset_hi", 64'(bus.result_hi), 64'd0);
    chk("midop_reset_dbz", 64'(bus.div_by_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    chk("midop_no_done_after_reset", 64'(done_seen), 64'd0);

    // Randomized ops, mixed idle gaps and back-to-back starts.
    @(negedge clk);
    for (int i = 0; i < 150; i++) begin
      r_op = 2'($urandom_range(3));
      case ($urandom_range(5))
        0:       r_a = 32'h80000000;
        1:       r_a = 32'hFFFFFFFF;
        2:       r_a = 32'($urandom_range(20));
        default: r_a = $urandom;
      endcase
      case ($urandom_range(6))
        0:       r_b = 32'h0;
        1:       r_b = 32'hFFFFFFFF;
        2:       r_b = 32'h80000000;
        3:       r_b = 32'($urandom_range(1, 15));
        default: r_b = $urandom;
      endcase
      if ($urandom_range(1) == 0) @(negedge clk);
      launch(r_op, r_a, r_b);
      model(r_op, r_a, r_b, e_lo, e_hi, e_dbz);
      wait_done(1'b0);
      check_result($sformatf("rand%0d_op%0d_a%h_b%h", i, r_op, r_a, r_b), e_lo, e_hi, e_dbz);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
